modexp_ctrl: RTL

Sequencer for RSA modular exponentiation, computing R = M^E mod N by right-to-left square-and-multiply. It multiplies with an internal serial shift-add multiplier. It is the initiator for the existing shift-subtract `mod` reduction unit: it drives `mod`'s go/X/Y inputs and consumes its done/R outputs for every reduction. It sits between the top-level RSA encrypt/decrypt wrapper and the `mod` instance.

---
 rtl/modexp_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: right-to-left square-and-multiply sequencer driving an external mod reduction unit
module modexp_ctrl #(
  parameter int BITS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [BITS-1:0]   M,
  input  logic [BITS-1:0]   E,
  input  logic [BITS-1:0]   N,
  output logic [BITS-1:0]   R,
  output logic              done,
  output logic              mod_go,
  output logic [2*BITS:0]   mod_X,
  output logic [2*BITS:0]   mod_Y,
  input  logic [BITS-1:0]   mod_R,
  input  logic              mod_done
);
  localparam int CW = $clog2(BITS) + 1;
  localparam logic [1:0] T_BASE = 2'd0;
  localparam logic [1:0] T_ACC = 2'd1;
  typedef enum logic [2:0] {IDLE, MUL, RED, REL, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [BITS-1:0] e_reg, n_reg, base, acc, mplier;
  logic [2*BITS-1:0] prod, mcand, prod_nx;
  logic [CW-1:0] cnt;
  logic [1:0] tgt;
  logic mul_f, sq_f, mul_last, take, e_more, do_mul, do_sq;
  assign prod_nx = mplier[0] ? prod + mcand : prod;
  assign mul_last = cnt == CW'(BITS - 1);
  assign take = mod_go && mod_done;
  assign e_more = |e_reg[BITS-1:1];
  assign do_mul = e_reg[0] && !mul_f;
  assign do_sq = e_more && !sq_f;
  assign mod_X = {{(BITS+1){1'b0}}, n_reg};
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !go ? IDLE : (~|N[BITS-1:1] || ~|E) ? DONE : RED;
      MUL: state_nx = mul_last ? RED : MUL;
      RED: state_nx = take ? REL : RED;
      REL: state_nx = mod_done ? REL : NEXT;
      NEXT: state_nx = (do_mul || do_sq) ? MUL : e_more ? NEXT : DONE;
      default: state_nx = DONE;
    endcase
    if (!go) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // mod_go rises only a cycle after mod_Y is loaded, and never while a stale done is pending
  always_ff @(posedge clk) begin
    if (reset) begin
      R <= '0;
      mod_go <= 1'b0;
      mod_Y <= '0;
      e_reg <= '0;
      n_reg <= '0;
      base <= '0;
      acc <= '0;
      prod <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      tgt <= T_BASE;
      mul_f <= 1'b0;
      sq_f <= 1'b0;
    end else begin
      mod_go <= go && state == RED && !mod_done;
      if (go) begin
        case (state)
          IDLE: begin
            e_reg <= E;
            n_reg <= N;
            acc <= BITS'(1);
            tgt <= T_BASE;
            mul_f <= 1'b0;
            sq_f <= 1'b0;
            mod_Y <= {{(BITS+1){1'b0}}, M};
            R <= ~|N[BITS-1:1] ? '0 : ~|E ? BITS'(1) : R;
          end
          MUL: begin
            prod <= prod_nx;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CW'(1);
            if (mul_last) mod_Y <= {1'b0, prod_nx};
          end
          RED: begin
            if (take && tgt == T_ACC) acc <= mod_R;
            if (take && tgt == T_BASE) base <= mod_R;
          end
          NEXT: begin
            if (do_mul || do_sq) begin
              mcand <= {{BITS{1'b0}}, do_mul ? acc : base};
              mplier <= base;
              prod <= '0;
              cnt <= '0;
              tgt <= do_mul ? T_ACC : T_BASE;
              mul_f <= mul_f || do_mul;
              sq_f <= sq_f || !do_mul;
            end else begin
              e_reg <= e_reg >> 1;
              mul_f <= 1'b0;
              sq_f <= 1'b0;
              if (!e_more) R <= acc;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
